// File: rtl/fft_dif_pair_feeder.sv
// Front end of a radix-2 DIF FFT stage: it buffers the first half of each frame and
// pairs every later sample with its partner and twiddle, feeding the stage butterfly.
package fft_dif_pair_feeder_pkg;
  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } complex_product_t;
endpackage

module fft_dif_pair_feeder
  import fft_dif_pair_feeder_pkg::*;
#(
  parameter int N       = 64,
  parameter int TW_FRAC = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  complex_product_t             in_data,
  output logic                         pair_valid,
  output complex_product_t             A,
  output complex_product_t             B,
  output logic signed [15:0]           W_R,
  output logic signed [15:0]           W_I,
  output logic [$clog2(N/2)-1:0]       pair_idx,
  output logic                         pair_last,
  output logic                         frame_err
);

  localparam int HALF  = N / 2;
  localparam int IDX_W = $clog2(HALF);

  typedef logic [HALF-1:0][31:0] rom_t;
  typedef enum logic { S_FILL, S_PAIR } state_t;

  // Round half away from zero into a 16-bit signed twiddle component.
  function automatic logic signed [15:0] q_round(input real v);
    if (v >= 0.0) return 16'($rtoi(v + 0.5));
    else          return 16'(-$rtoi(-v + 0.5));
  endfunction

  // Angles stay within [0, pi), so a plain Taylor series converges well here.
  function automatic rom_t build_rom();
    rom_t rom;
    real  x, s, c, ts, tc, scale;
    scale = 1.0;
    for (int i = 0; i < TW_FRAC; i++) scale = scale * 2.0;
    for (int k = 0; k < HALF; k++) begin
      x  = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
      s  = x;
      c  = 1.0;
      ts = x;
      tc = 1.0;
      for (int i = 1; i <= 20; i++) begin
        tc = -tc * x * x / real'((2 * i - 1) * (2 * i));
        ts = -ts * x * x / real'((2 * i) * (2 * i + 1));
        c  = c + tc;
        s  = s + ts;
      end
      rom[k] = {q_round(c * scale), q_round(-s * scale)};
    end
    return rom;
  endfunction

  localparam rom_t TW_ROM = build_rom();

  state_t           state;
  logic [IDX_W-1:0] idx;
  complex_product_t buf_mem [HALF];

  logic idx_last;
  logic abort;

  assign idx_last = (idx == IDX_W'(HALF - 1));
  assign abort    = in_sof && (state == S_PAIR || idx != '0);

  // NOTE: the sample buffer carries no reset; stale contents are always overwritten
  // during FILL before PAIR reads them, so resetting it would only cost logic.
  always_ff @(posedge clk) begin
    if (in_valid && (abort || state == S_FILL))
      buf_mem[abort ? IDX_W'(0) : idx] <= in_data;
  end

  // A mid-frame sof restarts the frame with this sample already in slot 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FILL;
      idx        <= '0;
      pair_valid <= 1'b0;
      frame_err  <= 1'b0;
      A          <= '0;
      B          <= '0;
      W_R        <= '0;
      W_I        <= '0;
      pair_idx   <= '0;
      pair_last  <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (in_valid) begin
        if (abort) begin
          state     <= S_FILL;
          idx       <= IDX_W'(1);
          frame_err <= 1'b1;
        end else if (state == S_FILL) begin
          idx <= idx_last ? '0 : idx + 1'b1;
          if (idx_last) state <= S_PAIR;
        end else begin
          pair_valid <= 1'b1;
          A          <= buf_mem[idx];
          B          <= in_data;
          W_R        <= TW_ROM[idx][31:16];
          W_I        <= TW_ROM[idx][15:0];
          pair_idx   <= idx;
          pair_last  <= idx_last;
          idx        <= idx_last ? '0 : idx + 1'b1;
          if (idx_last) state <= S_FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_dif_pair_feeder.sv
// Directed bench for fft_dif_pair_feeder at N=8: pairing, gaps, back-to-back frames,
// mid-frame sof recovery and reset, against hand-computed values.
module tb_fft_dif_pair_feeder;
  import fft_dif_pair_feeder_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_sof;
  complex_product_t in_data;
  logic             pair_valid;
  complex_product_t A;
  complex_product_t B;
  logic signed [15:0] W_R;
  logic signed [15:0] W_I;
  logic [1:0]       pair_idx;
  logic             pair_last;
  logic             frame_err;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] wr_exp [4] = '{16'sd16384, 16'sd11585, 16'sd0, -16'sd11585};
  logic signed [15:0] wi_exp [4] = '{16'sd0, -16'sd11585, -16'sd16384, -16'sd11585};

  fft_dif_pair_feeder #(.N(8), .TW_FRAC(14)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .pair_valid(pair_valid),
    .A         (A),
    .B         (B),
    .W_R       (W_R),
    .W_I       (W_I),
    .pair_idx  (pair_idx),
    .pair_last (pair_last),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic complex_product_t mk(input int v);
    complex_product_t c;
    c.re = 32'(v);
    c.im = 32'(-v);
    return c;
  endfunction

  // One clock with the given inputs; returns 1 ns after the edge so outputs are settled.
  task automatic step(input logic v, input logic s, input int n);
    in_valid = v;
    in_sof   = s;
    in_data  = mk(n);
    @(posedge clk);
    #1;
  endtask

  task automatic exp_pair(input string tag, input int k, input int a, input int b);
    check({tag, ".valid"}, 64'(pair_valid), 64'(1));
    check({tag, ".A"}, A, mk(a));
    check({tag, ".B"}, B, mk(b));
    check({tag, ".idx"}, 64'(pair_idx), 64'(k));
    check({tag, ".last"}, 64'(pair_last), 64'(k == 3));
    check({tag, ".wr"}, 64'(W_R), 64'(wr_exp[k]));
    check({tag, ".wi"}, 64'(W_I), 64'(wi_exp[k]));
  endtask

  task automatic exp_zero(input string tag);
    check({tag, ".valid"}, 64'(pair_valid), 64'(0));
    check({tag, ".err"}, 64'(frame_err), 64'(0));
    check({tag, ".A"}, A, 64'(0));
    check({tag, ".B"}, B, 64'(0));
    check({tag, ".wr"}, 64'(W_R), 64'(0));
    check({tag, ".wi"}, 64'(W_I), 64'(0));
    check({tag, ".idx"}, 64'(pair_idx), 64'(0));
    check({tag, ".last"}, 64'(pair_last), 64'(0));
  endtask

  // Sends an 8-sample frame base+1..base+8 and checks the four pairs it produces.
  task automatic frame(input string tag, input logic sof, input int base);
    for (int n = 0; n < 8; n++) begin
      step(1'b1, sof && n == 0, base + n + 1);
      if (n < 4) check({tag, ".fill"}, 64'(pair_valid), 64'(0));
      else       exp_pair(tag, n - 4, base + n - 3, base + n + 1);
    end
  endtask

  initial begin
    int npairs;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    exp_zero("rst0");
    reset = 1'b0;

    // Basic frame with sof.
    frame("f1", 1'b1, 0);

    // Gaps after samples 2 and 6.
    for (int n = 1; n <= 8; n++) begin
      step(1'b1, n == 1, n);
      if (n >= 5) exp_pair("gap", n - 5, n - 4, n);
      if (n == 2 || n == 6) begin
        step(1'b0, 1'b0, 99);
        check("gap.bubble", 64'(pair_valid), 64'(0));
        if (n == 6) begin
          check("gap.holdA", A, mk(2));
          check("gap.holdB", B, mk(6));
          check("gap.holdidx", 64'(pair_idx), 64'(1));
        end
      end
    end

    // Two back-to-back frames, sof only on the first.
    frame("b2b1", 1'b1, 10);
    frame("b2b2", 1'b0, 20);

    // sof on sample 6 aborts the frame; the sample becomes buf[0].
    for (int n = 1; n <= 5; n++) step(1'b1, n == 1, n);
    exp_pair("ab.pre", 0, 1, 5);
    step(1'b1, 1'b1, 6);
    check("ab.err", 64'(frame_err), 64'(1));
    check("ab.nopair", 64'(pair_valid), 64'(0));
    step(1'b1, 1'b0, 31);
    check("ab.errpulse", 64'(frame_err), 64'(0));
    check("ab.fill", 64'(pair_valid), 64'(0));
    step(1'b1, 1'b0, 32);
    step(1'b1, 1'b0, 33);
    check("ab.fill3", 64'(pair_valid), 64'(0));
    step(1'b1, 1'b0, 34);
    exp_pair("ab.p0", 0, 6, 34);
    step(1'b1, 1'b0, 35);
    exp_pair("ab.p1", 1, 31, 35);
    step(1'b1, 1'b0, 36);
    exp_pair("ab.p2", 2, 32, 36);
    step(1'b1, 1'b0, 37);
    exp_pair("ab.p3", 3, 33, 37);

    // Reset after five samples, then a fresh frame.
    for (int n = 1; n <= 5; n++) step(1'b1, n == 1, 40 + n);
    reset = 1'b1;
    step(1'b0, 1'b0, 0);
    reset = 1'b0;
    exp_zero("rst1");
    npairs = 0;
    for (int n = 0; n < 8; n++) begin
      step(1'b1, n == 0, 51 + n);
      if (pair_valid) npairs++;
      if (n >= 4) exp_pair("rst1.f", n - 4, 47 + n, 51 + n);
    end
    step(1'b0, 1'b0, 0);
    if (pair_valid) npairs++;
    check("rst1.count", 64'(npairs), 64'(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
